// File: rtl/top_cpu_mul_combine.sv
// Two-stage (A, W) reduction of the three 16x16 partial products into the low 32-bit mul result.
// Optional accumulate feature: define TOP_CPU_MUL_ACC_EN to add M_mul_acc/M_mul_acc_clr and the accumulator.
module top_cpu_mul_combine #(
  parameter int unsigned RESULT_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                M_en,
  input  logic                M_mul_valid,
  input  logic                M_flush,
  input  logic [RESULT_W-1:0] M_mul_cell_p1,
  input  logic [RESULT_W-1:0] M_mul_cell_p2,
  input  logic [RESULT_W-1:0] M_mul_cell_p3,
`ifdef TOP_CPU_MUL_ACC_EN
  input  logic                M_mul_acc,
  input  logic                M_mul_acc_clr,
`endif
  output logic [RESULT_W-1:0] W_mul_result,
  output logic                W_mul_valid
);

  localparam int unsigned HALF_W = RESULT_W / 2;

  logic [RESULT_W-1:0] a_p1_q;
  logic [HALF_W-1:0]   a_s_q, a_s_d;
  logic                a_valid_q, a_valid_d;
  logic [RESULT_W-1:0] w_result_q, w_result_d;
  logic                w_valid_q, w_valid_d;

  // Cross terms only contribute their low halves to the low result word.
  logic unused_hi_c;
  assign unused_hi_c = ^{M_mul_cell_p2[RESULT_W-1:HALF_W], M_mul_cell_p3[RESULT_W-1:HALF_W]};

`ifdef TOP_CPU_MUL_ACC_EN
  logic                a_acc_q, a_clr_q;
  logic [RESULT_W-1:0] acc_q;
  logic [RESULT_W-1:0] acc_base_c;

  // acc_q always mirrors the last valid W result, so back-to-back accumulates need no bypass.
  assign acc_base_c = (a_acc_q && !a_clr_q) ? acc_q : '0;
`endif

  always_comb begin
    a_s_d      = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
    a_valid_d  = M_mul_valid & ~M_flush;
    w_valid_d  = a_valid_q & ~M_flush;
    w_result_d = a_p1_q + {a_s_q, HALF_W'(0)};
`ifdef TOP_CPU_MUL_ACC_EN
    w_result_d = w_result_d + acc_base_c;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p1_q     <= '0;
      a_s_q      <= '0;
      a_valid_q  <= 1'b0;
      w_result_q <= '0;
      w_valid_q  <= 1'b0;
    end else if (M_en) begin
      a_p1_q     <= M_mul_cell_p1;
      a_s_q      <= a_s_d;
      a_valid_q  <= a_valid_d;
      w_result_q <= w_result_d;
      w_valid_q  <= w_valid_d;
    end
  end

`ifdef TOP_CPU_MUL_ACC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_acc_q <= 1'b0;
      a_clr_q <= 1'b0;
      acc_q   <= '0;
    end else if (M_en) begin
      a_acc_q <= M_mul_acc;
      a_clr_q <= M_mul_acc_clr;
      if (w_valid_d) acc_q <= w_result_d;
    end
  end
`endif

  assign W_mul_result = w_result_q;
  assign W_mul_valid  = w_valid_q;

endmodule

// File: tb/tb_top_cpu_mul_combine.sv
// Directed bench for top_cpu_mul_combine: streamed vector table plus stall, flush, reset and accumulate sequences.
module tb_top_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        M_en, M_mul_valid, M_flush;
  logic [31:0] p1, p2, p3;
  logic        acc, acc_clr;
  logic [31:0] W_mul_result;
  logic        W_mul_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  top_cpu_mul_combine #(.RESULT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_en          (M_en),
    .M_mul_valid   (M_mul_valid),
    .M_flush       (M_flush),
    .M_mul_cell_p1 (p1),
    .M_mul_cell_p2 (p2),
    .M_mul_cell_p3 (p3),
`ifdef TOP_CPU_MUL_ACC_EN
    .M_mul_acc     (acc),
    .M_mul_acc_clr (acc_clr),
`endif
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid)
  );

  typedef struct {
    logic [31:0] p1, p2, p3;
    logic        vld;
    logic [31:0] exp_res;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic v);
    p1 = a; p2 = b; p3 = c; M_mul_valid = v;
  endtask

  logic [31:0] frz_res;
  logic        frz_vld;

  initial begin
    vecs[0] = '{32'h4B4D2080, 32'hFFFFB020, 32'h000028C0, 1'b1, 32'h242D2080, 1'b1};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h0000FFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[2] = '{32'h00010000, 32'h00008000, 32'h00008000, 1'b1, 32'h00010000, 1'b1};
    vecs[3] = '{32'h0000000F, 32'h00000000, 32'h00000000, 1'b1, 32'h0000000F, 1'b1};
    vecs[4] = '{32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 32'h12345678, 1'b0};
    vecs[5] = '{32'h00000000, 32'hABCD0001, 32'h12340002, 1'b1, 32'h00030000, 1'b1};

    reset_n = 1'b0; M_en = 1'b0; M_flush = 1'b0; acc = 1'b0; acc_clr = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #12;
    chk("reset_result", W_mul_result, 32'h0);
    chk("reset_valid", 32'(W_mul_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    M_en = 1'b1;

    // Back-to-back stream; W shows vector i-1 after the edge that captures vector i.
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].vld);
      else       drive(32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      if (i >= 1) begin
        chk($sformatf("vec%0d_result", i-1), W_mul_result, vecs[i-1].exp_res);
        chk($sformatf("vec%0d_valid", i-1), 32'(W_mul_valid), 32'(vecs[i-1].exp_vld));
      end
    end

    // Stall: X, three disabled cycles with junk on the inputs, then Y.
    drive(32'h00000011, 32'h0, 32'h0, 1'b1);
    tick();
    frz_res = W_mul_result;
    frz_vld = W_mul_valid;
    M_en = 1'b0;
    drive(32'h0000DEAD, 32'h0000BEEF, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_result", k), W_mul_result, frz_res);
      chk($sformatf("stall%0d_valid", k), 32'(W_mul_valid), 32'(frz_vld));
    end
    M_en = 1'b1;
    drive(32'h00000022, 32'h0, 32'h0, 1'b1);
    tick();
    chk("stall_x_result", W_mul_result, 32'h00000011);
    chk("stall_x_valid", 32'(W_mul_valid), 32'h1);
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("stall_y_result", W_mul_result, 32'h00000022);
    chk("stall_y_valid", 32'(W_mul_valid), 32'h1);

    // Flush: P, X, then Y with M_flush while X sits in A.
    drive(32'h00000100, 32'h0, 32'h0, 1'b1);
    tick();
    drive(32'h00000200, 32'h0, 32'h0, 1'b1);
    tick();
    chk("flush_p_result", W_mul_result, 32'h00000100);
    chk("flush_p_valid", 32'(W_mul_valid), 32'h1);
    drive(32'h00000300, 32'h0, 32'h0, 1'b1);
    M_flush = 1'b1;
    #3;
    chk("flush_p_held", 32'(W_mul_valid), 32'h1);
    tick();
    M_flush = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    chk("flush_x_valid", 32'(W_mul_valid), 32'h0);
    chk("flush_x_data", W_mul_result, 32'h00000200);
    tick();
    chk("flush_y_valid", 32'(W_mul_valid), 32'h0);

    // Asynchronous reset mid-cycle with two multiplies in flight.
    drive(32'h00001234, 32'h0, 32'h0, 1'b1);
    tick();
    drive(32'h00005678, 32'h0, 32'h0, 1'b1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_result", W_mul_result, 32'h0);
    chk("arst_valid", 32'(W_mul_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h0000000F, 32'h0, 32'h0, 1'b1);
    tick();
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    chk("post_rst_bubble_valid", 32'(W_mul_valid), 32'h0);
    tick();
    chk("post_rst_result", W_mul_result, 32'h0000000F);
    chk("post_rst_valid", 32'(W_mul_valid), 32'h1);

`ifdef TOP_CPU_MUL_ACC_EN
    begin
      logic [31:0] ap[4]  = '{32'd15, 32'd10, 32'd7, 32'd4};
      logic        aa[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic        ac[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] ae[4]  = '{32'd15, 32'd25, 32'd32, 32'd4};
      for (int i = 0; i <= 4; i++) begin
        if (i < 4) begin
          drive(ap[i], 32'h0, 32'h0, 1'b1);
          acc = aa[i]; acc_clr = ac[i];
        end else begin
          drive(32'h0, 32'h0, 32'h0, 1'b0);
          acc = 1'b0; acc_clr = 1'b0;
        end
        tick();
        if (i >= 1) begin
          chk($sformatf("acc%0d_result", i-1), W_mul_result, ae[i-1]);
          chk($sformatf("acc%0d_valid", i-1), 32'(W_mul_valid), 32'h1);
        end
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/top_cpu_mul_combine.md
# top_cpu_mul_combine

- Downstream partner of the CPU multiply cell.
- Consumes the three registered 16x16 partial products (lo·lo, lo_a·hi_b, hi_a·lo_b) in the M stage.
- Reduces them over a two-stage pipeline (A, W) to the 32-bit low-word `mul` result for writeback.
- Carries an instruction-valid bit alongside the data, and supports stall (stage enable) and flush.

## Interface
Parameters:
- `RESULT_W`, 32: result width; only 32 is supported.

Ports:
- `clk` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `M_en` in 1: pipeline advance enable; all stage registers load only when high.
- `M_mul_valid` in 1: the M-stage instruction is a multiply; aligned with the partial products.
- `M_flush` in 1: kills the M-stage instruction and any A-stage instruction.
- `M_mul_cell_p1` in 32: `a[15:0]*b[15:0]`.
- `M_mul_cell_p2` in 32: `a[15:0]*b[31:16]`; bits [31:16] are ignored.
- `M_mul_cell_p3` in 32: `a[31:16]*b[15:0]`; bits [31:16] are ignored.
- `W_mul_result` out 32: product low word, registered.
- `W_mul_valid` out 1: `W_mul_result` holds a live multiply.
- `M_mul_acc` in 1: only with `TOP_CPU_MUL_ACC_EN`; accumulate into the previous result.
- `M_mul_acc_clr` in 1: only with `TOP_CPU_MUL_ACC_EN`; zero the accumulator base.

## Operation
**A stage** (loads on `M_en`):
- `A_p1 <= p1`.
- `A_s <= p2[15:0] + p3[15:0]` (16-bit, carry discarded).
- `A_valid <= M_mul_valid & ~M_flush`.
- The acc/clr flags are latched alongside when the macro is defined.

**W stage** (loads on `M_en`):
- `W_mul_result <= A_p1 + {A_s, 16'h0}` (mod 2^32).
- `W_mul_valid <= A_valid & ~M_flush`.

**Data gating:**
- Data registers load regardless of valid.
- Valid qualifies the data, and consumers must ignore the result when valid is 0.

**Stall:**
- With `M_en`=0, every register holds, including valids.
- Partial products presented during a stall are not captured.

**Flush:**
- `M_flush` takes effect only on an enabled edge.
- On that edge it clears the incoming valid at both A and W, so the results of the M and A instructions are dropped.
- An instruction already in W is unaffected.

**Reset** (asynchronous; also mid-operation):
- `A_p1`, `A_s`, `A_valid`, `W_mul_result`, `W_mul_valid` and the accumulator all go to 0 immediately.
- In-flight instructions are discarded.
- The first enabled edge after deassertion behaves normally.

No FSM; the block is a pure two-stage enabled pipeline.

## Timing
- **Latency:** a product presented in cycle N with `M_en`=1 appears on `W_mul_result` after the 2nd enabled edge.
  - With `M_en` continuously high, that is 2 clocks.
  - Each stalled cycle adds one.
- **Throughput:** one multiply per enabled cycle; back-to-back issue is supported.
- **Critical path:**
  - A stage: 16-bit add.
  - W stage: 32-bit add of `A_p1` with the high half `A_s`; no operand exceeds 32 bits.

## Configuration
`TOP_CPU_MUL_ACC_EN` defined:
- Ports `M_mul_acc` and `M_mul_acc_clr` exist, and a 32-bit accumulator register is added.
- W computes `result = (acc_flag ? acc_base : 0) + product`, where `acc_base` is the last valid `W_mul_result`.
- A valid W result is also written into the accumulator.
- `M_mul_acc_clr` forces `acc_base` to 0 and wins over `M_mul_acc` if both are set.
- Flushed or invalid slots never update the accumulator.
- Back-to-back accumulates forward the W result directly, with no bubble.

`TOP_CPU_MUL_ACC_EN` undefined:
- The acc ports and the accumulator are absent.
- The result is always the plain product.

## Test plan
1. **Basic product:** `p1=0x4B4D2080`, `p2=0xFFFFB020`, `p3=0x000028C0`, valid, `M_en`=1.
   - Required: `W_mul_result=0x242D2080` with valid 2 clocks later. This is `0x12345678*0x9ABCDEF0` low word; the upper bits of p2 are ignored.
2. **Carry discard:** `p1=0xFFFFFFFF`, `p2=0x0001`, `p3=0xFFFF`.
   - Required: `A_s=0x0000`, result `0xFFFFFFFF`.
   - Then `p1=0x00010000`, `p2=0x8000`, `p3=0x8000`: result `0x00010000`.
3. **Stall:** issue two multiplies back to back, drop `M_en` for 3 cycles between them.
   - Required: outputs are frozen during the stall.
   - Results appear in order at enabled edges 2 and 3, with no duplication or loss.
4. **Flush:** issue multiplies X then Y, then assert `M_flush` on the enabled edge where Y is in M and X is in A.
   - Required: `W_mul_valid` stays 0 for both X and Y.
   - A preceding multiply already in W keeps valid=1.
5. **Reset:** assert `reset_n`=0 mid-cycle with two multiplies in flight.
   - Required: all outputs are 0 immediately.
   - After release, a new multiply (`3*5` → `p1=15`, `p2=0`, `p3=0`) yields 15 with 2-clock latency.
6. **Accumulate** (`TOP_CPU_MUL_ACC_EN`): issue products 15, 10, 7 with acc=0, 1, 1, then 4 with clr=1 and acc=1.
   - Required: results 15, 25, 32, 4, back to back with no bubble.
